hazard_stall_ctrl: RTL

Central pipeline-control block that generates the stall, write-enable, flush and bubble controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and by the PC. It detects load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses. Memory accesses are handled through a req/ack handshake with a timeout. Saturating performance counters for stall and flush cycles are also maintained. It sits beside the ID stage and drives every pipeline register's control inputs.

---
 rtl/hazard_stall_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush/bubble control with load-use detection,
// data-memory req/ack handshake with timeout, and saturating stall/flush counters.
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rd_i,
   input  logic [4:0]       ifid_rs1_i,
   input  logic [4:0]       ifid_rs2_i,
   input  logic             branch_taken_i,
   input  logic             exmem_memaccess_i,
   input  logic             mem_ack_i,
   output logic             stall_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             mem_req_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      state;
   logic [15:0] wait_cnt;
   logic        in_wait, tmo, lu, lu_stall;
   assign in_wait = state == WAIT;
   assign tmo     = in_wait && wait_cnt == 16'(MEM_TIMEOUT - 1);
   assign lu      = idex_memread_i && idex_rd_i != 5'd0 &&
                    (idex_rd_i == ifid_rs1_i || idex_rd_i == ifid_rs2_i);
   // Reset forces every control to its pass-through value, even mid-WAIT.
   always_comb begin
      mem_req_o     = !rst_i && ((!in_wait && exmem_memaccess_i) || in_wait);
      stall_o       = !rst_i && ((!in_wait && exmem_memaccess_i) || (in_wait && !mem_ack_i && !tmo));
      lu_stall      = !rst_i && !stall_o && lu;
      ifid_flush_o  = !rst_i && !stall_o && !lu && branch_taken_i;
      idex_bubble_o = lu_stall;
      pc_write_o    = !(stall_o || lu_stall);
      ifid_write_o  = !(stall_o || lu_stall);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         mem_timeout_o <= 1'b0;
         stall_cnt_o   <= '0;
         flush_cnt_o   <= '0;
      end else begin
         if (!in_wait) begin
            state    <= exmem_memaccess_i ? WAIT : IDLE;
            wait_cnt <= '0;
         end else if (mem_ack_i) begin
            state <= IDLE;
         end else if (tmo) begin
            state         <= IDLE;
            mem_timeout_o <= 1'b1;
         end else begin
            wait_cnt <= wait_cnt + 16'd1;
         end
         if ((stall_o || lu_stall) && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         if (ifid_flush_o && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
   end
endmodule
